// File: rtl/fabric_config_loader.sv
// fabric_config_loader: assembles a serial LSB-first bit stream into tile frames, then
// switch-box frames, strobing each completed frame onto the shared configuration bus.
module fabric_config_loader #(
  parameter int NUM_TILES    = 4,
  parameter int NUM_SWITCHES = 4,
  parameter int TILE_BITS    = 33,
  parameter int SW_BITS      = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    bit_in_i,
  input  logic                    bit_valid_i,
  output logic                    bit_ready_o,
  output logic [TILE_BITS-1:0]    cfg_data_o,
  output logic [NUM_TILES-1:0]    tile_we_o,
  output logic [NUM_SWITCHES-1:0] sw_we_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int BW = $clog2(TILE_BITS);
  localparam int MF = NUM_TILES > NUM_SWITCHES ? NUM_TILES : NUM_SWITCHES;
  localparam int IW = MF > 1 ? $clog2(MF) : 1;
  typedef enum logic [2:0] {IDLE, SHIFT_TILE, WRITE_TILE, SHIFT_SW, WRITE_SW} state_t;
  state_t               state_q, state_d;
  logic [TILE_BITS-1:0] cfg_q, cfg_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 shifting, last_bit;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    done_d   = done_q;
    shifting = state_q == SHIFT_TILE || state_q == SHIFT_SW;
    last_bit = cnt_q == (state_q == SHIFT_TILE ? BW'(TILE_BITS - 1) : BW'(SW_BITS - 1));
    case (state_q)
      IDLE: if (start_i) begin
        cfg_d   = '0;
        cnt_d   = '0;
        idx_d   = '0;
        done_d  = NUM_TILES == 0 && NUM_SWITCHES == 0;
        state_d = NUM_TILES > 0 ? SHIFT_TILE : NUM_SWITCHES > 0 ? SHIFT_SW : IDLE;
      end
      SHIFT_TILE, SHIFT_SW: if (bit_valid_i) begin
        cfg_d = cfg_q | (TILE_BITS'(bit_in_i) << cnt_q);
        cnt_d = last_bit ? cnt_q : cnt_q + BW'(1);
        if (last_bit) state_d = state_q == SHIFT_TILE ? WRITE_TILE : WRITE_SW;
      end
      WRITE_TILE: begin
        cfg_d = '0;
        cnt_d = '0;
        if (idx_q == IW'(NUM_TILES - 1)) begin
          idx_d   = '0;
          done_d  = NUM_SWITCHES == 0;
          state_d = NUM_SWITCHES > 0 ? SHIFT_SW : IDLE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = SHIFT_TILE;
        end
      end
      WRITE_SW: begin
        cfg_d = '0;
        cnt_d = '0;
        if (idx_q == IW'(NUM_SWITCHES - 1)) begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = SHIFT_SW;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bit_ready_o = shifting;
  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q;
  assign cfg_data_o  = cfg_q;
  assign tile_we_o   = state_q == WRITE_TILE ? NUM_TILES'(1) << idx_q : '0;
  assign sw_we_o     = state_q == WRITE_SW ? NUM_SWITCHES'(1) << idx_q : '0;
endmodule

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: random-stream bench against a frame-queue model of the loader,
// plus a single-tile/single-switch instance for the smallest configuration.
module tb_fabric_config_loader;
  typedef struct {bit sw; int idx; logic [32:0] data;} fr_t;
  logic clk = 0, rst = 1;
  logic start = 0, bin = 0, bv = 0, rdy, busy, done;
  logic [32:0] cfg;
  logic [3:0] twe, swe;
  logic start1 = 0, bin1 = 0, bv1 = 0, rdy1, busy1, done1;
  logic [32:0] cfg1;
  logic [0:0] twe1, swe1;
  int tests = 0, fails = 0, cyc = 0, last_acc = 0, strobes = 0, rises = 0;
  logic done_p = 0;
  bit q_bits[$];
  fr_t exp_q[$];

  fabric_config_loader u_dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .bit_in_i(bin), .bit_valid_i(bv),
    .bit_ready_o(rdy), .cfg_data_o(cfg), .tile_we_o(twe), .sw_we_o(swe),
    .busy_o(busy), .done_o(done)
  );
  fabric_config_loader #(.NUM_TILES(1), .NUM_SWITCHES(1)) u_small (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .bit_in_i(bin1), .bit_valid_i(bv1),
    .bit_ready_o(rdy1), .cfg_data_o(cfg1), .tile_we_o(twe1), .sw_we_o(swe1),
    .busy_o(busy1), .done_o(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // every strobe must match the next frame the stream was built from
  always @(negedge clk) begin
    fr_t e;
    if (!rst && (|twe || |swe)) begin
      strobes++;
      check("onehot", 64'($countones({twe, swe})), 1);
      check("ready_in_write", rdy, 0);
      check("write_latency", 64'(cyc - last_acc), 1);
      if (exp_q.size() == 0) check("extra_strobe", {twe, swe}, 0);
      else begin
        e = exp_q.pop_front();
        check("write_target", {twe, swe}, e.sw ? {4'b0, 4'(1 << e.idx)} : {4'(1 << e.idx), 4'b0});
        check("write_data", cfg, e.data);
      end
    end
    if (done && !done_p) rises++;
    done_p = done;
  end

  task automatic build_pass(input bit rnd);
    logic [63:0] r;
    logic [32:0] d;
    q_bits.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom()};
      if (i < 4) d = rnd ? r[32:0] : 33'h1_0000_00A0 + 33'(i);
      else d = {17'b0, rnd ? r[15:0] : 16'(16'h8421 << (i - 4))};
      for (int b = 0; b < (i < 4 ? 33 : 16); b++) q_bits.push_back(d[b]);
      exp_q.push_back('{i >= 4, i % 4, d});
    end
  endtask

  // mode 0: valid always high, 1: valid low every third cycle, 2: random valid
  task automatic do_pass(input int mode, input bit rnd, input int start_at, input int abort_at);
    int acc = 0, stalls = 0, first = 0, s0 = strobes, r0 = rises, k = 0, b = 0;
    build_pass(rnd);
    bv = 1;
    bin = q_bits[0];
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    while (1) begin
      @(negedge clk);
      if (k == 0) begin
        first = cyc;
        check("start_latency_ready", rdy, 1);
        check("done_falls", done, 0);
      end
      if (rdy && !bv) stalls++;
      if (rdy && bv) begin
        void'(q_bits.pop_front());
        acc++;
        last_acc = cyc;
      end
      @(posedge clk); #1;
      k++;
      if (q_bits.size() == 0 || acc == abort_at) break;
      if (k > 3000) begin
        check("stream_timeout", 0, 1);
        break;
      end
      bv = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 != 2) : ($urandom_range(0, 3) != 0);
      bin = q_bits[0];
      start = acc == start_at;
    end
    bv = 0;
    start = 0;
    if (acc == abort_at) begin
      rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 0;
      check("abort_strobe_count", 64'(strobes - s0), 1);
      exp_q.delete();
      q_bits.delete();
      repeat (5) @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      return;
    end
    do begin
      @(negedge clk);
      b++;
    end while (!done && b < 100);
    check("done_seen", done, 1);
    check("pass_cycles", 64'(cyc - first), 64'(4 * (33 + 1) + 4 * (16 + 1) + stalls));
    check("frames_left", 64'(exp_q.size()), 0);
    check("strobe_count", 64'(strobes - s0), 8);
    check("idle_busy", busy, 0);
    check("cfg_cleared", cfg, 0);
    repeat (3) @(negedge clk);
    check("done_held", done, 1);
    check("done_rises", 64'(rises - r0), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int nt = 0, ns = 0, first1 = 0, got_done = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_outputs", {rdy, busy, done, twe, swe, cfg}, 0);
    check("reset_small", {rdy1, busy1, done1, twe1, swe1, cfg1}, 0);
    @(posedge clk); #1 rst = 0;
    bv = 1;
    repeat (10) begin
      @(negedge clk);
      check("idle_quiet", {rdy, busy, done, twe, swe, cfg}, 0);
    end
    @(posedge clk); #1 bv = 0;
    do_pass(0, 0, -1, -1);
    do_pass(1, 0, -1, -1);
    do_pass(0, 0, -1, 50);
    do_pass(0, 0, -1, -1);
    do_pass(0, 1, 4 * 33 + 2 * 16 + 10, -1);
    do_pass(2, 1, -1, -1);
    bv1 = 1;
    bin1 = 1;
    start1 = 1;
    @(posedge clk); #1 start1 = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(negedge clk);
      if (i == 0) first1 = cyc;
      if (twe1[0]) begin
        nt++;
        check("small_tile_data", cfg1, 33'h1_FFFF_FFFF);
      end
      if (swe1[0]) begin
        ns++;
        check("small_sw_after_tile", 64'(nt), 1);
        check("small_sw_data", cfg1, 33'h0_0000_FFFF);
      end
      if (done1) begin
        got_done = 1;
        check("small_pass_cycles", 64'(cyc - first1), 51);
      end
    end
    check("small_done", 64'(got_done), 1);
    check("small_strobes", 64'({nt[7:0], ns[7:0]}), 16'h0101);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
